// File: rtl/qpsk_demapper_if.sv
// Symbol-in / bit-out stream bundle for the QPSK demapper.
// master = surrounding logic (symbol source and bit sink); slave = the demapper.
interface qpsk_demapper_if #(
   parameter int unsigned WIDTH = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_re;
   logic signed [WIDTH-1:0] in_im;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_bit;
   logic                    out_first;

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_bit, out_first
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_bit, out_first
   );
endinterface

// File: rtl/qpsk_demapper.sv
// QPSK hard-decision slicer: sign decisions buffered in a FIFO, serialised as bit1 (re) then bit2 (im).
// Optional macro DEMAP_ERR_EN builds the saturating decision-error accumulator.
module qpsk_demapper #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned AMP        = 46341,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   qpsk_demapper_if.slave     bus,
   input  logic               clr_stats,
   output logic [CNT_W-1:0]   sym_cnt,
   output logic [47:0]        err_acc
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTF_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, BIT1, BIT2} state_t;

   logic [1:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNTF_W-1:0] count;
   logic [1:0]        head;
   logic              push, pop, not_empty;

   state_t state, state_n;
   logic   out_valid_q, out_bit_q, out_first_q, b2_q;
   logic   valid_n, bit_n, first_n, b2_n, cnt_inc;

   assign bus.in_ready  = !rst && (count != CNTF_W'(FIFO_DEPTH));
   assign push          = bus.in_valid && bus.in_ready;
   assign not_empty     = (count != '0);
   assign head          = mem[rd_ptr];
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = out_bit_q;
   assign bus.out_first = out_first_q;

   // Decision FIFO: each entry holds {re<0, im<0}
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {bus.in_re[WIDTH-1], bus.in_im[WIDTH-1]};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTF_W'(1);
            2'b01:   count <= count - CNTF_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_first_q <= 1'b0;
         b2_q        <= 1'b0;
      end else begin
         state       <= state_n;
         out_valid_q <= valid_n;
         out_bit_q   <= bit_n;
         out_first_q <= first_n;
         b2_q        <= b2_n;
      end
   end

   // Serialiser: BIT2 reloads straight into BIT1 so back-to-back symbols have no bubble
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      cnt_inc = 1'b0;
      valid_n = out_valid_q;
      bit_n   = out_bit_q;
      first_n = out_first_q;
      b2_n    = b2_q;
      case (state)
         IDLE: begin
            if (not_empty) begin
               pop     = 1'b1;
               valid_n = 1'b1;
               bit_n   = head[1];
               first_n = 1'b1;
               b2_n    = head[0];
               state_n = BIT1;
            end
         end
         BIT1: begin
            if (bus.out_ready) begin
               bit_n   = b2_q;
               first_n = 1'b0;
               state_n = BIT2;
            end
         end
         BIT2: begin
            if (bus.out_ready) begin
               cnt_inc = 1'b1;
               if (not_empty) begin
                  pop     = 1'b1;
                  bit_n   = head[1];
                  first_n = 1'b1;
                  b2_n    = head[0];
                  state_n = BIT1;
               end else begin
                  valid_n = 1'b0;
                  bit_n   = 1'b0;
                  first_n = 1'b0;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            valid_n = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sym_cnt <= '0;
      else if (clr_stats)
         sym_cnt <= '0;
      else if (cnt_inc)
         sym_cnt <= sym_cnt + CNT_W'(1);
   end

`ifdef DEMAP_ERR_EN
   localparam int unsigned AW = WIDTH + 1;

   // Distance of |x| from the nominal amplitude; the extra bit keeps |-2^(WIDTH-1)| exact
   function automatic logic [AW-1:0] dev(input logic [WIDTH-1:0] x);
      logic [AW-1:0] ext, mag, amp;
      ext = {x[WIDTH-1], x};
      mag = x[WIDTH-1] ? (~ext + AW'(1)) : ext;
      amp = AW'(AMP);
      return (mag >= amp) ? (mag - amp) : (amp - mag);
   endfunction

   logic [AW:0] err_sum;
   logic [48:0] acc_sum;

   assign err_sum = {1'b0, dev(bus.in_re)} + {1'b0, dev(bus.in_im)};
   assign acc_sum = {1'b0, err_acc} + 49'(err_sum);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_acc <= '0;
      else if (clr_stats)
         err_acc <= '0;
      else if (push)
         err_acc <= acc_sum[48] ? '1 : acc_sum[47:0];
   end
`else
   // Only the sign bits are needed when error tracking is not built
   logic unused_mag;
   assign unused_mag = ^{bus.in_re[WIDTH-2:0], bus.in_im[WIDTH-2:0]};
   assign err_acc    = '0;
`endif

endmodule
